// File: rtl/bus_pkg.sv
// Shared types and helpers for the AS/DS/DSACK bus initiator.
// Covers FSM states, SIZ and status codes, port-width decode and write lane steering.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_STRB = 3'd2,
    ST_WAIT = 3'd3,
    ST_TERM = 3'd4,
    ST_RESP = 3'd5
  } busState_t;

  localparam logic [1:0] SIZ_LONG     = 2'b00;
  localparam logic [1:0] SIZ_BYTE     = 2'b01;
  localparam logic [1:0] SIZ_WORD     = 2'b10;
  localparam logic [1:0] SIZ_3BYTE    = 2'b11;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_BERR    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  localparam logic [1:0] DSACK_NONE   = 2'b11;

  function automatic logic [2:0] sizBytes(input logic [1:0] siz);
    logic [2:0] n;
    case (siz)
      SIZ_BYTE:  n = 3'd1;
      SIZ_WORD:  n = 3'd2;
      SIZ_3BYTE: n = 3'd3;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  // Zero means the slave has not terminated the cycle.
  function automatic logic [2:0] portBytes(input logic [1:0] dsackN);
    logic [2:0] n;
    case (dsackN)
      2'b00:   n = 3'd4;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Which remaining operand byte lands on a given lane; low lanes replicate for narrow ports.
  function automatic logic [1:0] writeLaneSrc(input logic [1:0] addrLow, input logic [1:0] lane);
    logic [1:0] src;
    if (lane >= addrLow) begin
      src = lane - addrLow;
    end else if (addrLow == 2'd2 && lane == 2'd1) begin
      src = 2'd1;
    end else begin
      src = 2'd0;
    end
    return src;
  endfunction

endpackage

// File: rtl/bus_cycle_master_lane_mux.sv
// Combinational lane steering for one bus sub-cycle: byte count, write lanes, read capture.
module bus_lane_mux
  import bus_pkg::*;
(
  input  logic [1:0]  addrLow,
  input  logic [2:0]  portSize,
  input  logic [2:0]  remBytes,
  input  logic [2:0]  movedBytes,
  input  logic [31:0] wrOperand,
  input  logic [31:0] rdLanes,
  input  logic [31:0] accIn,
  output logic [31:0] wrLanes,
  output logic [2:0]  xferBytes,
  output logic [31:0] accOut
);

  logic [1:0]      laneStart;
  logic [2:0]      room;
  logic [1:0]      srcIdx;
  logic [1:0]      dstIdx;
  logic [3:0][7:0] wrV;
  logic [3:0][7:0] rdV;
  logic [3:0][7:0] accV;
  logic [3:0][7:0] laneV;

  // Byte index 0 is the most significant byte, which maps to packed element 3.
  always_comb begin
    laneStart = addrLow & 2'(portSize - 3'd1);
    room      = portSize - {1'b0, laneStart};
    xferBytes = (remBytes < room) ? remBytes : room;
    wrV       = wrOperand;
    rdV       = rdLanes;
    accV      = accIn;
    laneV     = 32'd0;
    srcIdx    = 2'd0;
    dstIdx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      laneV[2'd3 - 2'(i)] = wrV[2'd3 - writeLaneSrc(addrLow, 2'(i))];
      srcIdx = laneStart + 2'(i);
      dstIdx = 2'(movedBytes + 3'(i));
      accV[2'd3 - dstIdx] = (3'(i) < xferBytes) ? rdV[2'd3 - srcIdx] : accV[2'd3 - dstIdx];
    end
    wrLanes = laneV;
    accOut  = accV;
  end

endmodule

// File: rtl/bus_cycle_master.sv
// Master end of the AS/DS/DSACK asynchronous bus: turns one-shot requests into
// dynamically sized bus cycles with bus-error and timeout termination.
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              sysClk,
  input  logic              sysRESET,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqData,
  input  logic [1:0]        reqSize,
  input  logic              reqRWn,
  output logic              rspValid,
  output logic [31:0]       rspData,
  output logic [1:0]        rspStatus,
  output logic [ADDR_W-1:0] busAddr,
  output logic [1:0]        busSIZ,
  output logic              busRWn,
  output logic              busASn,
  output logic              busDSn,
  output logic [31:0]       busDataOut,
  output logic              busDataOE,
  input  logic [31:0]       busDataIn,
  input  logic [1:0]        busDSACKn,
  input  logic              busBERRn
);

  busState_t   state;
  busState_t   nextState;
  logic        rwnLat;
  logic [2:0]  opBytes;
  logic [2:0]  remBytes;
  logic [2:0]  movedBytes;
  logic [2:0]  xferLat;
  logic [2:0]  xferBytes;
  logic [2:0]  portSize;
  logic [31:0] wrOperand;
  logic [31:0] acc;
  logic [31:0] accNext;
  logic [31:0] wrLanes;
  logic [7:0]  timer;
  logic [1:0]  statusLat;
  logic        termSeen;
  logic        nextASn;
  logic        nextDSn;
  logic        nextOE;
  logic        nextReady;
  logic        nextRspValid;

  assign portSize = portBytes(busDSACKn);
  assign termSeen = !busBERRn || (busDSACKn != DSACK_NONE);

  bus_lane_mux uLaneMux (
    .addrLow    (busAddr[1:0]),
    .portSize   (portSize),
    .remBytes   (remBytes),
    .movedBytes (movedBytes),
    .wrOperand  (wrOperand),
    .rdLanes    (busDataIn),
    .accIn      (acc),
    .wrLanes    (wrLanes),
    .xferBytes  (xferBytes),
    .accOut     (accNext)
  );

  // State register.
  always_ff @(posedge sysClk) begin
    if (sysRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (reqValid) nextState = ST_ADDR;
        else          nextState = ST_IDLE;
      end
      ST_ADDR: nextState = ST_STRB;
      ST_STRB: nextState = ST_WAIT;
      ST_WAIT: begin
        if (termSeen || timer == 8'd1) nextState = ST_TERM;
        else                           nextState = ST_WAIT;
      end
      ST_TERM: begin
        if (statusLat == STAT_OK && remBytes != xferLat) nextState = ST_ADDR;
        else                                             nextState = ST_RESP;
      end
      ST_RESP: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Strobe and handshake values for the state being entered, so they leave from flops.
  always_comb begin
    nextASn      = 1'b1;
    nextDSn      = 1'b1;
    nextOE       = 1'b0;
    nextReady    = 1'b0;
    nextRspValid = 1'b0;
    case (nextState)
      ST_IDLE: nextReady = 1'b1;
      ST_ADDR: nextOE = 1'b0;
      ST_STRB: begin
        nextASn = 1'b0;
        nextDSn = !rwnLat;
        nextOE  = !rwnLat;
      end
      ST_WAIT: begin
        nextASn = 1'b0;
        nextDSn = 1'b0;
        nextOE  = !rwnLat;
      end
      ST_TERM: nextOE = !rwnLat;
      ST_RESP: nextRspValid = 1'b1;
      default: nextReady = 1'b1;
    endcase
  end

  // Registered strobes and handshakes.
  always_ff @(posedge sysClk) begin
    if (sysRESET) begin
      busASn    <= 1'b1;
      busDSn    <= 1'b1;
      busDataOE <= 1'b0;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
    end else begin
      busASn    <= nextASn;
      busDSn    <= nextDSn;
      busDataOE <= nextOE;
      reqReady  <= nextReady;
      rspValid  <= nextRspValid;
    end
  end

  // Request capture, sub-cycle advance, timeout counter and response registers.
  always_ff @(posedge sysClk) begin
    if (sysRESET) begin
      busAddr    <= '0;
      busSIZ     <= SIZ_LONG;
      busRWn     <= 1'b1;
      busDataOut <= 32'd0;
      rwnLat     <= 1'b1;
      opBytes    <= 3'd4;
      remBytes   <= 3'd4;
      movedBytes <= 3'd0;
      xferLat    <= 3'd0;
      wrOperand  <= 32'd0;
      acc        <= 32'd0;
      timer      <= 8'd0;
      statusLat  <= STAT_OK;
      rspData    <= 32'd0;
      rspStatus  <= STAT_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            busAddr    <= reqAddr;
            busSIZ     <= reqSize;
            busRWn     <= reqRWn;
            rwnLat     <= reqRWn;
            opBytes    <= sizBytes(reqSize);
            remBytes   <= sizBytes(reqSize);
            movedBytes <= 3'd0;
            acc        <= 32'd0;
            statusLat  <= STAT_OK;
            // Left-justify the operand so remaining byte 0 is always the top byte.
            wrOperand  <= reqRWn ? 32'd0 : (reqData << {3'd4 - sizBytes(reqSize), 3'b000});
          end
        end
        ST_ADDR: busDataOut <= wrLanes;
        ST_STRB: timer <= 8'(TIMEOUT);
        ST_WAIT: begin
          timer <= timer - 8'd1;
          if (nextState == ST_TERM) begin
            xferLat <= xferBytes;
            if (!busBERRn) begin
              statusLat <= STAT_BERR;
            end else if (busDSACKn != DSACK_NONE) begin
              statusLat <= STAT_OK;
              acc       <= accNext;
            end else begin
              statusLat <= STAT_TIMEOUT;
            end
          end
        end
        ST_TERM: begin
          if (nextState == ST_ADDR) begin
            busAddr    <= busAddr + ADDR_W'(xferLat);
            remBytes   <= remBytes - xferLat;
            busSIZ     <= 2'(remBytes - xferLat);
            movedBytes <= movedBytes + xferLat;
            wrOperand  <= wrOperand << {xferLat, 3'b000};
          end else begin
            rspStatus <= statusLat;
            rspData   <= (rwnLat && statusLat == STAT_OK) ?
                         (acc >> {3'd4 - opBytes, 3'b000}) : 32'd0;
          end
        end
        ST_RESP: busRWn <= 1'b1;
        default: busRWn <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Scoreboard bench for bus_cycle_master: a bus slave model replays queued terminations,
// expected sub-cycles and responses are queued with each request and checked as they appear.
module tb_bus_cycle_master;

  logic        sysClk = 1'b0;
  logic        sysRESET = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] reqAddr = 32'd0;
  logic [31:0] reqData = 32'd0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqRWn = 1'b1;
  logic        rspValid;
  logic [31:0] rspData;
  logic [1:0]  rspStatus;
  logic [31:0] busAddr;
  logic [1:0]  busSIZ;
  logic        busRWn;
  logic        busASn;
  logic        busDSn;
  logic [31:0] busDataOut;
  logic        busDataOE;
  logic [31:0] busDataIn = 32'd0;
  logic [1:0]  busDSACKn = 2'b11;
  logic        busBERRn = 1'b1;

  always #5 sysClk = ~sysClk;

  bus_cycle_master #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .sysClk(sysClk), .sysRESET(sysRESET),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqData(reqData),
    .reqSize(reqSize), .reqRWn(reqRWn),
    .rspValid(rspValid), .rspData(rspData), .rspStatus(rspStatus),
    .busAddr(busAddr), .busSIZ(busSIZ), .busRWn(busRWn), .busASn(busASn), .busDSn(busDSn),
    .busDataOut(busDataOut), .busDataOE(busDataOE), .busDataIn(busDataIn),
    .busDSACKn(busDSACKn), .busBERRn(busBERRn)
  );

  typedef struct packed { logic [31:0] addr; logic [1:0] siz; logic rwn; logic chkData; logic [31:0] data; } cyc_t;
  typedef struct packed { logic [1:0] dsack; logic berr; logic [31:0] lanes; } drv_t;
  typedef struct packed { logic [1:0] status; logic chkData; logic [31:0] data; } res_t;

  cyc_t expCycQ[$];
  drv_t drvQ[$];
  res_t expRspQ[$];
  int   checkCount = 0;
  int   errCount = 0;
  int   rspCount = 0;
  logic prevASn = 1'b1;
  logic curDrvValid = 1'b0;
  drv_t curDrv;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expCyc(input logic [31:0] a, input logic [1:0] s, input logic r, input logic c, input logic [31:0] d);
    expCycQ.push_back('{a, s, r, c, d});
  endtask

  task automatic slaveDrv(input logic [1:0] ds, input logic be, input logic [31:0] lanes);
    drvQ.push_back('{ds, be, lanes});
  endtask

  task automatic expRsp(input logic [1:0] st, input logic c, input logic [31:0] d);
    expRspQ.push_back('{st, c, d});
  endtask

  // Bus slave model and output monitor, both on the falling edge.
  always @(negedge sysClk) begin
    cyc_t c;
    res_t r;
    if (!busASn && prevASn) begin
      if (expCycQ.size() == 0) begin
        checkVal("extra bus cycle", 64'd1, 64'd0);
      end else begin
        c = expCycQ.pop_front();
        checkVal("busAddr", busAddr, c.addr);
        checkVal("busSIZ", busSIZ, c.siz);
        checkVal("busRWn", busRWn, c.rwn);
        if (c.chkData) begin
          checkVal("busDataOE", busDataOE, 64'd1);
          checkVal("busDataOut", busDataOut, c.data);
        end else begin
          checkVal("busDataOE read", busDataOE, 64'd0);
        end
      end
      curDrvValid = (drvQ.size() != 0);
      if (curDrvValid) curDrv = drvQ.pop_front();
    end
    if (busASn) begin
      busDSACKn   = 2'b11;
      busBERRn    = 1'b1;
      busDataIn   = 32'd0;
      curDrvValid = 1'b0;
    end else if (!busDSn && curDrvValid) begin
      busDSACKn = curDrv.dsack;
      busBERRn  = !curDrv.berr;
      busDataIn = curDrv.lanes;
    end
    if (rspValid) begin
      rspCount++;
      if (expRspQ.size() == 0) begin
        checkVal("extra response", 64'd1, 64'd0);
      end else begin
        r = expRspQ.pop_front();
        checkVal("rspStatus", rspStatus, r.status);
        if (r.chkData) checkVal("rspData", rspData, r.data);
      end
    end
    prevASn = busASn;
  end

  task automatic runXfer(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic rwn, output int lat, output int dsLow);
    int startRsp;
    int n;
    @(negedge sysClk);
    checkVal({name, " reqReady idle"}, reqReady, 64'd1);
    reqValid = 1'b1; reqAddr = a; reqData = d; reqSize = s; reqRWn = rwn;
    startRsp = rspCount;
    n = 0;
    dsLow = 0;
    @(posedge sysClk);
    while (rspCount == startRsp && n < 100) begin
      @(negedge sysClk);
      #1;
      n++;
      if (!busDSn) dsLow++;
      // A second request while busy must be ignored.
      reqValid = (n == 2);
      reqAddr  = 32'hDEAD0000;
      if (n == 2) checkVal({name, " reqReady busy"}, reqReady, 64'd0);
    end
    reqValid = 1'b0;
    if (rspCount == startRsp) checkVal({name, " response wait expired"}, 64'd0, 64'd1);
    lat = n;
    repeat (3) @(negedge sysClk);
    #1;
    checkVal({name, " response count"}, 64'(rspCount - startRsp), 64'd1);
    checkVal({name, " cycles outstanding"}, 64'(expCycQ.size()), 64'd0);
    checkVal({name, " strobes idle"}, {busASn, busDSn, busDataOE}, 64'b110);
  endtask

  initial begin
    int lat;
    int dsLow;
    int startRsp;
    int n;

    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    checkVal("reset reqReady", reqReady, 64'd1);
    checkVal("reset busASn", busASn, 64'd1);
    checkVal("reset busDSn", busDSn, 64'd1);
    checkVal("reset busRWn", busRWn, 64'd1);
    checkVal("reset busDataOE", busDataOE, 64'd0);
    checkVal("reset rspValid", rspValid, 64'd0);
    checkVal("reset rspStatus", rspStatus, 64'd0);
    checkVal("reset rspData", rspData, 64'd0);
    checkVal("reset busAddr", busAddr, 64'd0);
    checkVal("reset busSIZ", busSIZ, 64'd0);
    sysRESET = 1'b0;

    // Long write to a 32-bit port, best-case latency.
    expCyc(32'h00100000, 2'b00, 1'b0, 1'b1, 32'h12345678);
    slaveDrv(2'b00, 1'b0, 32'd0);
    expRsp(2'b00, 1'b1, 32'd0);
    runXfer("wr long", 32'h00100000, 32'h12345678, 2'b00, 1'b0, lat, dsLow);
    checkVal("wr long latency", 64'(lat), 64'd5);

    // Misaligned long read from an 8-bit port.
    expCyc(32'h00200001, 2'b00, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00200002, 2'b11, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00200003, 2'b10, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00200004, 2'b01, 1'b1, 1'b0, 32'd0);
    slaveDrv(2'b10, 1'b0, 32'hAA000000);
    slaveDrv(2'b10, 1'b0, 32'hBB000000);
    slaveDrv(2'b10, 1'b0, 32'hCC000000);
    slaveDrv(2'b10, 1'b0, 32'hDD000000);
    expRsp(2'b00, 1'b1, 32'hAABBCCDD);
    runXfer("rd long 8b", 32'h00200001, 32'd0, 2'b00, 1'b1, lat, dsLow);

    // Word read straddling a 16-bit port boundary.
    expCyc(32'h00300003, 2'b10, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00300004, 2'b01, 1'b1, 1'b0, 32'd0);
    slaveDrv(2'b01, 1'b0, 32'h115A2233);
    slaveDrv(2'b01, 1'b0, 32'hC3445566);
    expRsp(2'b00, 1'b1, 32'h00005AC3);
    runXfer("rd word 16b", 32'h00300003, 32'd0, 2'b10, 1'b1, lat, dsLow);

    // Bus error together with DSACK on the second sub-cycle: BERR wins, rest abandoned.
    expCyc(32'h00400000, 2'b11, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00400001, 2'b10, 1'b1, 1'b0, 32'd0);
    slaveDrv(2'b10, 1'b0, 32'h01000000);
    slaveDrv(2'b00, 1'b1, 32'h02000000);
    expRsp(2'b01, 1'b0, 32'd0);
    runXfer("berr", 32'h00400000, 32'd0, 2'b11, 1'b1, lat, dsLow);

    // No termination at all: timeout after 16 WAIT clocks.
    expCyc(32'h00500000, 2'b00, 1'b0, 1'b1, 32'h55AA55AA);
    expRsp(2'b10, 1'b0, 32'd0);
    runXfer("timeout", 32'h00500000, 32'h55AA55AA, 2'b00, 1'b0, lat, dsLow);
    checkVal("timeout wait clocks", 64'(dsLow), 64'd16);

    // Write lane replication cases.
    expCyc(32'h00500001, 2'b11, 1'b0, 1'b1, 32'hA1A1B2C3);
    slaveDrv(2'b00, 1'b0, 32'd0);
    expRsp(2'b00, 1'b1, 32'd0);
    runXfer("wr 3byte A1", 32'h00500001, 32'h00A1B2C3, 2'b11, 1'b0, lat, dsLow);

    expCyc(32'h00600002, 2'b10, 1'b0, 1'b1, 32'hBEEFBEEF);
    slaveDrv(2'b01, 1'b0, 32'd0);
    expRsp(2'b00, 1'b1, 32'd0);
    runXfer("wr word A2", 32'h00600002, 32'h0000BEEF, 2'b10, 1'b0, lat, dsLow);

    expCyc(32'h00700003, 2'b00, 1'b0, 1'b1, 32'hCACACACA);
    expCyc(32'h00700004, 2'b11, 1'b0, 1'b1, 32'hFEF00D00);
    slaveDrv(2'b00, 1'b0, 32'd0);
    slaveDrv(2'b00, 1'b0, 32'd0);
    expRsp(2'b00, 1'b1, 32'd0);
    runXfer("wr long A3", 32'h00700003, 32'hCAFEF00D, 2'b00, 1'b0, lat, dsLow);

    // Address wrap at the top of the space.
    expCyc(32'hFFFFFFFF, 2'b10, 1'b1, 1'b0, 32'd0);
    expCyc(32'h00000000, 2'b01, 1'b1, 1'b0, 32'd0);
    slaveDrv(2'b10, 1'b0, 32'h12000000);
    slaveDrv(2'b10, 1'b0, 32'h34000000);
    expRsp(2'b00, 1'b1, 32'h00001234);
    runXfer("rd wrap", 32'hFFFFFFFF, 32'd0, 2'b10, 1'b1, lat, dsLow);

    // Reset while a write waits for termination.
    expCyc(32'h00800000, 2'b00, 1'b0, 1'b1, 32'h0BADF00D);
    startRsp = rspCount;
    @(negedge sysClk);
    reqValid = 1'b1; reqAddr = 32'h00800000; reqData = 32'h0BADF00D; reqSize = 2'b00; reqRWn = 1'b0;
    @(posedge sysClk);
    @(negedge sysClk);
    #1;
    reqValid = 1'b0;
    n = 0;
    while (busDSn && n < 20) begin
      @(negedge sysClk);
      #1;
      n++;
    end
    checkVal("rst reached WAIT", busDSn, 64'd0);
    @(negedge sysClk);
    sysRESET = 1'b1;
    @(posedge sysClk);
    #1;
    checkVal("rst busASn", busASn, 64'd1);
    checkVal("rst busDSn", busDSn, 64'd1);
    checkVal("rst busDataOE", busDataOE, 64'd0);
    checkVal("rst reqReady", reqReady, 64'd1);
    checkVal("rst rspValid", rspValid, 64'd0);
    @(negedge sysClk);
    sysRESET = 1'b0;
    repeat (25) @(negedge sysClk);
    #1;
    checkVal("rst no response", 64'(rspCount - startRsp), 64'd0);
    checkVal("rst cycles outstanding", 64'(expCycQ.size()), 64'd0);
    checkVal("rst stays idle", {busASn, reqReady}, 64'b11);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
